itcm_arbiter: RTL and testbench
===============================

# itcm_arbiter

Two-requester arbiter that shares the single-port instruction tightly-coupled memory (ITCM) between the IFU fetch port and the LSU data port. It sits between `ifu_ifetch`/LSU and the ITCM controller. It grants one command per cycle and records the source of every issued command in an in-order routing FIFO, so each memory response returns to the requester that issued it. It also discards in-flight IFU responses when the pipeline is flushed.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.
- `OUTS_DEPTH`, 2: maximum number of outstanding memory commands (1..4).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ifu_req_valid` in 1, `ifu_req_ready` out 1, `ifu_req_pc` in AW: IFU fetch command.
- `ifu_rsp_valid` out 1, `ifu_rsp_ready` in 1, `ifu_rsp_instr` out DW: IFU response.
- `ifu_flush` in 1: single-cycle pulse; drop IFU responses still in flight.
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_req_addr` in AW, `lsu_req_wdata` in DW, `lsu_req_we` in 1, `lsu_req_wmask` in DW/8: LSU command.
- `lsu_rsp_valid` out 1, `lsu_rsp_ready` in 1, `lsu_rsp_rdata` out DW: LSU response (writes also return one response).
- `mem_cmd_valid` out 1, `mem_cmd_ready` in 1, `mem_cmd_addr` out AW, `mem_cmd_wdata` out DW, `mem_cmd_we` out 1, `mem_cmd_wmask` out DW/8: ITCM command.
- `mem_rsp_valid` in 1, `mem_rsp_ready` out 1, `mem_rsp_rdata` in DW: ITCM response, returned in order.

## Operation
- Routing FIFO: OUTS_DEPTH entries of {src, discard}, where src is 0 for IFU and 1 for LSU.
  - Push on a `mem_cmd` handshake; pop on a `mem_rsp` handshake.
  - Push and pop in the same cycle leave the count unchanged.
- Issue gating: `mem_cmd_valid = (ifu_req_valid | lsu_req_valid) & ~fifo_full`. There is no full-bypass; a pop in the same cycle does not allow a push when full.
- Grant: the winner's fields drive `mem_cmd_*`. For an IFU grant, `we=0`, `wmask=0`, `wdata=0`.
  - `ifu_req_ready = grant_ifu & mem_cmd_ready & ~fifo_full`; `lsu_req_ready` is symmetric.
- Response steering uses the FIFO head:
  - src=IFU, discard=0: `ifu_rsp_valid = mem_rsp_valid`; `mem_rsp_ready = ifu_rsp_ready`.
  - src=LSU: `lsu_rsp_valid = mem_rsp_valid`; `mem_rsp_ready = lsu_rsp_ready`.
  - discard=1: `mem_rsp_ready = 1`, and neither requester sees a valid.
  - FIFO empty: `mem_rsp_ready = 0`.
  - The response data buses pass `mem_rsp_rdata` through unconditionally.
- Flush: `ifu_flush` sets discard on every valid FIFO entry with src=IFU.
  - This includes the head entry if its response is in its handshake cycle.
  - An IFU command pushed in the flush cycle is NOT marked; it carries the post-flush PC.
  - LSU entries are unaffected.
- Arbitration policy is set by the macro in Configuration.

## Timing
- Reset values:
  - FIFO empty, all discard bits 0, rr pointer = IFU.
  - All `*_valid` outputs 0 and all ready outputs 0. `mem_rsp_ready` is 0 because the FIFO is empty.
- Command path is combinational: request to `mem_cmd_valid` in 0 cycles.
- Response path is combinational: `mem_rsp` to requester rsp in 0 cycles.
- Throughput: one command per cycle while the FIFO is not full. With an ITCM of 1-cycle latency and OUTS_DEPTH=2, IFU back-to-back fetch runs at 1 instruction/cycle.
- Requesters must hold `valid` and payload until ready. The arbiter may switch its grant while a request waits unaccepted.
- Reset mid-operation: the FIFO is cleared and any in-flight memory responses are lost. The ITCM controller is reset by the same `rst_n`.

## Configuration
- `ITCM_ARB_RR_EN` defined: round-robin.
  - If both requesters are valid, grant goes to the one not granted at the last `mem_cmd` handshake.
  - The rr pointer updates only on a handshake.
- `ITCM_ARB_RR_EN` not defined: fixed priority, LSU over IFU. No rr pointer state exists.

## Structure
- Shared package/defines hold:
  - `ITCM_SRC_IFU=1'b0` and `ITCM_SRC_LSU=1'b1`.
  - The FIFO entry struct {src, discard}.
  - The `OUTS_DEPTH` default.
- One sub-module, `itcm_arb_route_fifo`:
  - Small in-order FIFO with per-entry src and discard bits.
  - Ports: push, pop, flush_ifu, full, empty, head fields.
- Arbitration and steering stay in the top level.

## Test plan
- IFU only, PCs 0x80, 0x84, 0x88 back-to-back, 1-cycle ITCM -> three `mem_cmd` in consecutive cycles, and `ifu_rsp_instr` returns the three words in order.
- IFU and LSU both valid for 4 cycles:
  - With RR_EN: grants alternate IFU, LSU, IFU, LSU.
  - Without RR_EN: LSU granted every cycle and `ifu_req_ready` stays 0.
- ITCM holds responses (`mem_rsp_valid=0`) while 2 commands are outstanding -> `mem_cmd_valid=0` and both `req_ready=0` until the first response pops.
- Issue IFU@0x100 and LSU load@0x2000, then pulse `ifu_flush` -> the IFU response is dropped with `mem_rsp_ready=1` and `ifu_rsp_valid=0`; the LSU load data still reaches `lsu_rsp_rdata`.
- Flush pulsed in the same cycle as an IFU command to 0x200 -> the 0x200 response is delivered with `ifu_rsp_valid=1`.
- LSU holds `lsu_rsp_ready=0` for 3 cycles with an LSU head entry -> `mem_rsp_ready=0`, and the response is delivered when ready rises.
- Assert `rst_n` low with 2 entries outstanding -> after release, FIFO is empty and all valids are 0.

Source files
------------

// File: rtl/itcm_arbiter_pkg.sv
// Shared definitions for the ITCM arbiter: source encodings, the routing FIFO
// entry layout, and the default number of outstanding memory commands.
package itcm_arbiter_pkg;

    localparam logic ITCM_SRC_IFU = 1'b0;
    localparam logic ITCM_SRC_LSU = 1'b1;

    localparam int unsigned ITCM_OUTS_DEPTH_DEFAULT = 2;

    // One routing FIFO entry: which requester issued the command and whether
    // its response must be dropped because the IFU was flushed.
    typedef struct packed {
        logic src;
        logic discard;
    } itcm_route_t;

    // Pointer width for a FIFO of the given depth (never narrower than 1 bit).
    function automatic int unsigned itcm_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/itcm_arb_route_fifo.sv
// In-order routing FIFO for the ITCM arbiter. Each entry records the source of
// an issued memory command plus a discard flag set by an IFU flush.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_src    enqueue an entry for a command handshake (ignored when full)
//   pop               dequeue the head on a response handshake (ignored when empty)
//   flush_ifu         mark every valid IFU entry as discard
//   full, empty       occupancy status
//   head_src          source of the head entry
//   head_discard      head must be dropped (includes a flush in this very cycle)
module itcm_arb_route_fifo
    import itcm_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = ITCM_OUTS_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_src,
    input  logic pop,
    input  logic flush_ifu,
    output logic full,
    output logic empty,
    output logic head_src,
    output logic head_discard
);

    localparam int unsigned PTR_W = itcm_ptr_w(DEPTH);

    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    itcm_route_t [DEPTH-1:0] ent_q, ent_d;

    logic push_ok;
    logic pop_ok;

    // Wrapping increment that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (32'(p) == DEPTH - 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = &vld_q;
    assign empty   = ~|vld_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // A flush in the head's handshake cycle must drop that response too, so
    // the flush is folded into the head view combinationally.
    assign head_src     = ent_q[rptr_q].src;
    assign head_discard = ent_q[rptr_q].discard
                        | (flush_ifu & vld_q[rptr_q] & (ent_q[rptr_q].src == ITCM_SRC_IFU));

    // Next-state: flush marking, then pop, then push (new entries are never marked).
    always_comb begin
        vld_d  = vld_q;
        ent_d  = ent_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;

        if (flush_ifu) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (vld_q[i] && (ent_q[i].src == ITCM_SRC_IFU)) begin
                    ent_d[i].discard = 1'b1;
                end
            end
        end

        if (pop_ok) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = ptr_inc(rptr_q);
        end

        if (push_ok) begin
            vld_d[wptr_q] = 1'b1;
            ent_d[wptr_q] = '{src: push_src, discard: 1'b0};
            wptr_d        = ptr_inc(wptr_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            ent_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ent_q  <= ent_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/itcm_arbiter.sv
// Shares the single-port ITCM between the IFU fetch port and the LSU data port.
// One command is granted per cycle; the source of each issued command is kept in
// an in-order routing FIFO so responses return to their issuer. IFU responses
// still in flight are dropped when the pipeline is flushed.
//
// Configuration: define ITCM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with LSU over IFU.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   ifu_req_* / ifu_rsp_* / ifu_flush   IFU fetch command, response, flush pulse
//   lsu_req_* / lsu_rsp_*               LSU load/store command and response
//   mem_cmd_* / mem_rsp_*               ITCM command and in-order response
module itcm_arbiter
    import itcm_arbiter_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned OUTS_DEPTH = ITCM_OUTS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_req_pc,
    output logic            ifu_rsp_valid,
    input  logic            ifu_rsp_ready,
    output logic [DW-1:0]   ifu_rsp_instr,
    input  logic            ifu_flush,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_req_addr,
    input  logic [DW-1:0]   lsu_req_wdata,
    input  logic            lsu_req_we,
    input  logic [DW/8-1:0] lsu_req_wmask,
    output logic            lsu_rsp_valid,
    input  logic            lsu_rsp_ready,
    output logic [DW-1:0]   lsu_rsp_rdata,

    output logic            mem_cmd_valid,
    input  logic            mem_cmd_ready,
    output logic [AW-1:0]   mem_cmd_addr,
    output logic [DW-1:0]   mem_cmd_wdata,
    output logic            mem_cmd_we,
    output logic [DW/8-1:0] mem_cmd_wmask,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [DW-1:0]   mem_rsp_rdata
);

    logic fifo_full;
    logic fifo_empty;
    logic head_src;
    logic head_discard;
    logic grant_lsu;
    logic grant_ifu;
    logic cmd_hs;
    logic rsp_hs;

    // Arbitration: pick the winner among valid requesters.
`ifdef ITCM_ARB_RR_EN
    // Source that wins the next contested cycle; moves only on a handshake.
    logic rr_q, rr_d;

    always_comb begin
        grant_lsu = lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = (rr_q == ITCM_SRC_LSU);
        end
        rr_d = rr_q;
        if (cmd_hs) begin
            rr_d = grant_lsu ? ITCM_SRC_IFU : ITCM_SRC_LSU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= ITCM_SRC_IFU;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign grant_lsu = lsu_req_valid;
`endif

    assign grant_ifu = ifu_req_valid & ~grant_lsu;

    // Command path: no issue when the routing FIFO is full, even if it pops now.
    assign mem_cmd_valid = (ifu_req_valid | lsu_req_valid) & ~fifo_full;
    assign ifu_req_ready = grant_ifu & mem_cmd_ready & ~fifo_full;
    assign lsu_req_ready = grant_lsu & mem_cmd_ready & ~fifo_full;
    assign cmd_hs        = mem_cmd_valid & mem_cmd_ready;

    // Winner's payload onto the ITCM command; fetches are always reads.
    always_comb begin
        mem_cmd_addr  = ifu_req_pc;
        mem_cmd_wdata = '0;
        mem_cmd_we    = 1'b0;
        mem_cmd_wmask = '0;
        if (grant_lsu) begin
            mem_cmd_addr  = lsu_req_addr;
            mem_cmd_wdata = lsu_req_wdata;
            mem_cmd_we    = lsu_req_we;
            mem_cmd_wmask = lsu_req_wmask;
        end
    end

    // Response steering from the routing FIFO head.
    always_comb begin
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        if (!fifo_empty) begin
            if (head_discard) begin
                mem_rsp_ready = 1'b1;
            end else if (head_src == ITCM_SRC_LSU) begin
                lsu_rsp_valid = mem_rsp_valid;
                mem_rsp_ready = lsu_rsp_ready;
            end else begin
                ifu_rsp_valid = mem_rsp_valid;
                mem_rsp_ready = ifu_rsp_ready;
            end
        end
    end

    assign rsp_hs        = mem_rsp_valid & mem_rsp_ready;
    assign ifu_rsp_instr = mem_rsp_rdata;
    assign lsu_rsp_rdata = mem_rsp_rdata;

    itcm_arb_route_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_route_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (cmd_hs),
        .push_src     (grant_lsu ? ITCM_SRC_LSU : ITCM_SRC_IFU),
        .pop          (rsp_hs),
        .flush_ifu    (ifu_flush),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .head_src     (head_src),
        .head_discard (head_discard)
    );

endmodule

// File: tb/tb_itcm_arbiter.sv
// Directed bench for itcm_arbiter: a cycle-by-cycle vector table with the ITCM
// responses driven by hand, plus short sequences for arbitration and reset.
module tb_itcm_arbiter;

    localparam logic [31:0] WD = 32'h1234_5678;
    localparam logic [3:0]  WM = 4'hA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_flush;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic        lsu_req_we;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        mem_cmd_valid, mem_cmd_ready;
    logic [31:0] mem_cmd_addr, mem_cmd_wdata;
    logic        mem_cmd_we;
    logic [3:0]  mem_cmd_wmask;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    itcm_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_instr (ifu_rsp_instr),
        .ifu_flush     (ifu_flush),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_wdata (mem_cmd_wdata),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_wmask (mem_cmd_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        lv;
        logic [31:0] la;
        logic        we;
        logic        rv;
        logic [31:0] rd;
        logic        lrr;
        logic        fl;
        logic        e_cv;
        logic [31:0] e_ca;
        logic        e_we;
        logic        e_ir;
        logic        e_lr;
        logic        e_mr;
        logic        e_iv;
        logic        e_lv;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic iv, input logic [31:0] pc, input logic lv, input logic [31:0] la,
        input logic we, input logic rv, input logic [31:0] rd, input logic lrr, input logic fl,
        input logic e_cv, input logic [31:0] e_ca, input logic e_we, input logic e_ir,
        input logic e_lr, input logic e_mr, input logic e_iv, input logic e_lv);
        vec_t v;
        v.iv = iv; v.pc = pc; v.lv = lv; v.la = la; v.we = we; v.rv = rv; v.rd = rd;
        v.lrr = lrr; v.fl = fl; v.e_cv = e_cv; v.e_ca = e_ca; v.e_we = e_we;
        v.e_ir = e_ir; v.e_lr = e_lr; v.e_mr = e_mr; v.e_iv = e_iv; v.e_lv = e_lv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before sampling.
    task automatic drive(input logic iv, input logic [31:0] pc, input logic lv,
                         input logic [31:0] la, input logic we, input logic rv,
                         input logic [31:0] rd, input logic lrr, input logic fl);
        @(negedge clk);
        ifu_req_valid = iv;
        ifu_req_pc    = pc;
        lsu_req_valid = lv;
        lsu_req_addr  = la;
        lsu_req_we    = we;
        lsu_req_wdata = WD;
        lsu_req_wmask = WM;
        mem_cmd_ready = 1'b1;
        mem_rsp_valid = rv;
        mem_rsp_rdata = rd;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = lrr;
        ifu_flush     = fl;
        #1;
    endtask

    initial begin
        logic exp_lsu;
        vec_t v;

        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_req_pc = '0; ifu_rsp_ready = 1'b0; ifu_flush = 1'b0;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_we = 1'b0;
        lsu_req_wmask = '0; lsu_rsp_ready = 1'b0;
        mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

        // iv pc lv la we rv rd lrr fl | cv ca we ir lr mr iv lv
        // IFU back-to-back fetch with a 1-cycle ITCM.
        vq.push_back(mk(1, 32'h80, 0, 0, 0, 0, 0,            1, 0, 1, 32'h80, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h84, 0, 0, 0, 1, 32'hA000_0000, 1, 0, 1, 32'h84, 0, 1, 0, 1, 1, 0));
        vq.push_back(mk(1, 32'h88, 0, 0, 0, 1, 32'hA000_0001, 1, 0, 1, 32'h88, 0, 1, 0, 1, 1, 0));
        vq.push_back(mk(0, 0,      0, 0, 0, 1, 32'hA000_0002, 1, 0, 0, 0,      0, 0, 0, 1, 1, 0));
        // Two outstanding, ITCM holds responses: issue blocked until a pop.
        vq.push_back(mk(1, 32'h90, 0, 0,          0, 0, 0,            1, 0, 1, 32'h90,   0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h94, 0, 0,          0, 0, 0,            1, 0, 1, 32'h94,   0, 1, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h98, 1, 32'h3000,   0, 0, 0,            1, 0, 0, 0,        0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h98, 1, 32'h3000,   0, 1, 32'hA000_0003, 1, 0, 0, 0,        0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 32'h98, 1, 32'h3000,   0, 1, 32'hA000_0004, 1, 0, 1, 32'h3000, 0, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 32'h98, 0, 0,          0, 1, 32'hB000_0000, 1, 0, 1, 32'h98,   0, 1, 0, 1, 0, 1));
        vq.push_back(mk(0, 0,      0, 0,          0, 1, 32'hA000_0005, 1, 0, 0, 0,        0, 0, 0, 1, 1, 0));
        // Flush drops the in-flight fetch, LSU load still delivered.
        vq.push_back(mk(1, 32'h100, 0, 0,         0, 0, 0,            1, 0, 1, 32'h100,  0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       1, 32'h2000,  0, 0, 0,            1, 0, 1, 32'h2000, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0,       0, 0,         0, 0, 0,            1, 1, 0, 0,        0, 0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0,       0, 0,         0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0,        0, 0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0,       0, 0,         0, 1, 32'hB000_0001, 1, 0, 0, 0,        0, 0, 0, 1, 0, 1));
        // Flush in the same cycle as the post-flush fetch: not dropped.
        vq.push_back(mk(1, 32'h200, 0, 0,         0, 0, 0,            1, 1, 1, 32'h200,  0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0,       0, 0,         0, 1, 32'hA000_0006, 1, 0, 0, 0,        0, 0, 0, 1, 1, 0));
        // LSU store, then LSU back-pressures its response for 3 cycles.
        vq.push_back(mk(0, 0, 1, 32'h2004, 1, 0, 0,            0, 0, 1, 32'h2004, 1, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,        0, 1, 32'hB000_0002, 0, 0, 0, 0,        0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0,        0, 1, 32'hB000_0002, 0, 0, 0, 0,        0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0,        0, 1, 32'hB000_0002, 0, 0, 0, 0,        0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0,        0, 1, 32'hB000_0002, 1, 0, 0, 0,        0, 0, 0, 1, 0, 1));

        // Reset state.
        #1;
        chk("reset_outputs",
            64'({mem_cmd_valid, ifu_req_ready, lsu_req_ready, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}),
            64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.iv, v.pc, v.lv, v.la, v.we, v.rv, v.rd, v.lrr, v.fl);
            chk($sformatf("vec%0d_flags", i),
                64'({mem_cmd_valid, mem_cmd_we, ifu_req_ready, lsu_req_ready,
                     mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}),
                64'({v.e_cv, v.e_we, v.e_ir, v.e_lr, v.e_mr, v.e_iv, v.e_lv}));
            if (v.e_cv) begin
                chk($sformatf("vec%0d_addr", i), 64'(mem_cmd_addr), 64'(v.e_ca));
                chk($sformatf("vec%0d_wdata_wmask", i), 64'({mem_cmd_wdata, mem_cmd_wmask}),
                    v.e_lr ? 64'({WD, WM}) : 64'(0));
            end
            if (v.e_iv) chk($sformatf("vec%0d_instr", i), 64'(ifu_rsp_instr), 64'(v.rd));
            if (v.e_lv) chk($sformatf("vec%0d_rdata", i), 64'(lsu_rsp_rdata), 64'(v.rd));
        end

        // Both requesters valid for 4 cycles with a 1-cycle ITCM.
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h400, 1, 32'h5000, 0, (k > 0), 32'hC000_0000 + 32'(k), 1, 0);
`ifdef ITCM_ARB_RR_EN
            exp_lsu = k[0];
`else
            exp_lsu = 1'b1;
`endif
            chk($sformatf("contend%0d_addr", k), 64'(mem_cmd_addr),
                exp_lsu ? 64'(32'h5000) : 64'(32'h400));
            chk($sformatf("contend%0d_ready", k), 64'({ifu_req_ready, lsu_req_ready}),
                64'({~exp_lsu, exp_lsu}));
        end
        drive(0, 0, 0, 0, 0, 1, 32'hC000_0004, 1, 0);
        chk("contend_drain_rsp_ready", 64'(mem_rsp_ready), 64'(1));

        // Reset with two commands outstanding.
        drive(1, 32'h600, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_fill0", 64'({mem_cmd_valid, ifu_req_ready}), 64'(2'b11));
        drive(1, 32'h604, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_fill1", 64'({mem_cmd_valid, ifu_req_ready, mem_rsp_ready}), 64'(3'b111));
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_asserted", 64'({mem_cmd_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'hD000_0000, 1, 0);
        chk("rst_released_empty",
            64'({mem_cmd_valid, ifu_req_ready, lsu_req_ready, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}),
            64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
